cdb_arbiter: RTL and testbench

CDB_ARBITER -- requirements
Module: cdb_arbiter

---
 rtl/cdb_arbiter.sv | 116 +++++++++++
 tb/tb_cdb_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one holding buffer per functional unit, round-robin
// grant among full buffers, one broadcast per cycle driven from registers only.
module cdb_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int TAG_W   = 3,
  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ*TAG_W-1:0]  req_tag,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      cdb_valid,
  output logic [DATA_W-1:0]         cdb_data,
  output logic [TAG_W-1:0]          cdb_tag,
  output logic [IDX_W-1:0]          cdb_src
);

  logic [NUM_REQ-1:0] full_reg;
  logic [NUM_REQ-1:0] full_next;
  logic [DATA_W-1:0]  data_reg [NUM_REQ];
  logic [TAG_W-1:0]   tag_reg  [NUM_REQ];
  logic [IDX_W-1:0]   ptr_reg;
  logic [IDX_W-1:0]   ptr_next;

  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   grant_idx;
  logic               any_full;
  logic [NUM_REQ-1:0] load;
  logic [DATA_W-1:0]  in_data [NUM_REQ];
  logic [TAG_W-1:0]   in_tag  [NUM_REQ];

  assign any_full = |full_reg;

  // Round-robin search: first full buffer at or after ptr, wrapping to 0.
  always_comb begin
    logic found;
    logic [IDX_W-1:0] cand;
    int idx;
    found     = 1'b0;
    cand      = '0;
    idx       = 0;
    grant     = '0;
    grant_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr_reg) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cand = IDX_W'(idx);
      if (!found && full_reg[cand]) begin
        found     = 1'b1;
        grant_idx = cand;
      end
    end
    grant[grant_idx] = found;
  end

  // Per-requester handshake: a buffer accepts when empty or when it is being
  // drained this cycle; nothing is accepted during reset or flush.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_buf
    assign in_data[gi]   = req_data[gi*DATA_W +: DATA_W];
    assign in_tag[gi]    = req_tag[gi*TAG_W +: TAG_W];
    assign req_ready[gi] = !rst && !flush && (!full_reg[gi] || (grant[gi] && any_full));
    assign load[gi]      = req_valid[gi] && req_ready[gi];
    // A reload in the grant cycle keeps the buffer full with the new entry.
    assign full_next[gi] = load[gi] || (full_reg[gi] && !grant[gi]);
  end

  // Pointer advances past the granted index only when a broadcast happens.
  always_comb begin
    ptr_next = ptr_reg;
    if (any_full) begin
      if (grant_idx == IDX_W'(NUM_REQ - 1)) ptr_next = '0;
      else                                  ptr_next = grant_idx + 1'b1;
    end
  end

  // Control state: reset beats flush; flush empties buffers but keeps ptr.
  always_ff @(posedge clk) begin
    if (rst) begin
      full_reg <= '0;
      ptr_reg  <= '0;
    end else if (flush) begin
      full_reg <= '0;
    end else begin
      full_reg <= full_next;
      ptr_reg  <= ptr_next;
    end
  end

  // Payload storage; contents are only observed while the full bit is set.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (load[i]) begin
        data_reg[i] <= in_data[i];
        tag_reg[i]  <= in_tag[i];
      end
    end
  end

  // Broadcast outputs come from registers only and are zeroed when idle.
  always_comb begin
    cdb_valid = any_full;
    cdb_data  = '0;
    cdb_tag   = '0;
    cdb_src   = '0;
    if (any_full) begin
      cdb_data = data_reg[grant_idx];
      cdb_tag  = tag_reg[grant_idx];
      cdb_src  = grant_idx;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Testbench for cdb_arbiter: directed scenarios plus random traffic, checked
// against a queue-based model of pending results per requester.
module tb_cdb_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int TW = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic [N-1:0]      req_valid;
  logic [N*DW-1:0]   req_data;
  logic [N*TW-1:0]   req_tag;
  logic [N-1:0]      req_ready;
  logic              cdb_valid;
  logic [DW-1:0]     cdb_data;
  logic [TW-1:0]     cdb_tag;
  logic [1:0]        cdb_src;

  cdb_arbiter #(.NUM_REQ(N), .DATA_W(DW), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_data(req_data), .req_tag(req_tag),
    .req_ready(req_ready), .cdb_valid(cdb_valid), .cdb_data(cdb_data),
    .cdb_tag(cdb_tag), .cdb_src(cdb_src)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: each requester holds a queue of accepted-but-not-broadcast results.
  typedef struct packed {
    logic [DW-1:0] d;
    logic [TW-1:0] t;
  } ent_t;
  ent_t m_q [N][$];
  int   m_ptr = 0;

  logic           obs_valid;
  logic [1:0]     obs_src;
  logic [DW-1:0]  obs_data;
  logic [TW-1:0]  obs_tag;
  logic [N-1:0]   obs_ready;
  int             cyc = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock: drive inputs at negedge, compare outputs, then advance model.
  task automatic cycle(input logic [N-1:0] v, input logic [N*DW-1:0] d,
                       input logic [N*TW-1:0] t, input logic f, input logic r,
                       input bit chk);
    int g;
    bit any;
    logic [N-1:0] exp_ready;
    ent_t e;
    @(negedge clk);
    req_valid = v; req_data = d; req_tag = t; flush = f; rst = r;
    #1;
    cyc++;
    g = 0; any = 0;
    for (int k = 0; k < N; k++) begin
      int j;
      j = (m_ptr + k) % N;
      if (!any && m_q[j].size() > 0) begin any = 1; g = j; end
    end
    for (int i = 0; i < N; i++)
      exp_ready[i] = !r && !f && (m_q[i].size() == 0 || (any && g == i));
    if (chk) begin
      check("cdb_valid", 64'(cdb_valid), 64'(any));
      if (any) begin
        e = m_q[g][0];
        check("cdb_src",  64'(cdb_src),  64'(g));
        check("cdb_data", 64'(cdb_data), 64'(e.d));
        check("cdb_tag",  64'(cdb_tag),  64'(e.t));
      end else begin
        check("idle_bus", {cdb_data, 29'(cdb_tag), cdb_src}, 64'd0);
      end
      check("req_ready", 64'(req_ready), 64'(exp_ready));
    end
    obs_valid = cdb_valid; obs_src = cdb_src; obs_data = cdb_data;
    obs_tag = cdb_tag; obs_ready = req_ready;
    if (r) begin
      for (int i = 0; i < N; i++) m_q[i].delete();
      m_ptr = 0;
    end else if (f) begin
      for (int i = 0; i < N; i++) m_q[i].delete();
    end else begin
      if (any) begin
        void'(m_q[g].pop_front());
        m_ptr = (g + 1) % N;
      end
      for (int i = 0; i < N; i++)
        if (v[i] && exp_ready[i]) m_q[i].push_back({d[i*DW +: DW], t[i*TW +: TW]});
    end
  endtask

  task automatic idle(input bit chk);
    cycle('0, '0, '0, 1'b0, 1'b0, chk);
  endtask

  task automatic do_reset();
    cycle('0, '0, '0, 1'b0, 1'b1, 1'b1);
  endtask

  int k;
  int first_c, last_c, seen;
  logic [TW-1:0] tg;

  initial begin
    rst = 1'b1; flush = 1'b0; req_valid = '0; req_data = '0; req_tag = '0;
    // Power-up: register contents unknown until the first reset edge.
    cycle('0, '0, '0, 1'b0, 1'b1, 1'b0);
    cycle('0, '0, '0, 1'b0, 1'b1, 1'b1);
    check("reset_valid", 64'(obs_valid), 64'd0);
    check("reset_ready", 64'(obs_ready), 64'd0);

    // Single request on index 2.
    cycle(4'b0100, 128'hAB << 64, 12'(5) << 6, 1'b0, 1'b0, 1'b1);
    idle(1'b1);
    check("single_valid", 64'(obs_valid), 64'd1);
    check("single_data",  64'(obs_data),  64'hAB);
    check("single_tag",   64'(obs_tag),   64'd5);
    check("single_src",   64'(obs_src),   64'd2);
    idle(1'b1);
    check("single_after", 64'(obs_valid), 64'd0);
    // ptr is now 3: all four at once must start at index 3.
    cycle(4'b1111, {32'd13, 32'd12, 32'd11, 32'd10}, {3'd3, 3'd2, 3'd1, 3'd0}, 1'b0, 1'b0, 1'b1);
    idle(1'b1);
    check("ptr3_first", 64'(obs_src), 64'd3);
    repeat (4) idle(1'b1);

    // Round-robin from ptr 0.
    do_reset();
    cycle(4'b1111, {32'd23, 32'd22, 32'd21, 32'd20}, {3'd7, 3'd6, 3'd5, 3'd4}, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      idle(1'b1);
      check("rr_valid", 64'(obs_valid), 64'd1);
      check("rr_src",   64'(obs_src),   64'(i));
    end
    idle(1'b1);
    check("rr_idle", 64'(obs_valid), 64'd0);

    // Backpressure: all requesters held valid; model checks ready each cycle.
    for (int c = 0; c < 12; c++)
      cycle(4'b1111, {$urandom, $urandom, $urandom, $urandom}, 12'($urandom), 1'b0, 1'b0, 1'b1);
    repeat (5) idle(1'b1);

    // Streaming on requester 0 with tags 0..7.
    do_reset();
    k = 0; seen = 0; first_c = -1; last_c = -1;
    for (int c = 0; c < 40 && (k < 8 || seen < 8); c++) begin
      if (k < 8) cycle(4'b0001, 128'(32'(100 + k)), 12'(k), 1'b0, 1'b0, 1'b1);
      else       idle(1'b1);
      if (obs_valid) begin
        check("stream_tag", 64'(obs_tag), 64'(seen));
        if (first_c < 0) first_c = cyc;
        last_c = cyc;
        seen++;
      end
      if (k < 8 && obs_ready[0]) k++;
    end
    check("stream_count", 64'(seen), 64'd8);
    check("stream_b2b",   64'(last_c - first_c), 64'd7);

    // Flush with buffers 0 and 3 full.
    do_reset();
    cycle(4'b1001, {32'h333, 64'd0, 32'h111}, {3'd3, 6'd0, 3'd1}, 1'b0, 1'b0, 1'b1);
    cycle('0, '0, '0, 1'b1, 1'b0, 1'b1);
    check("flush_valid", 64'(obs_valid), 64'd1);
    check("flush_src",   64'(obs_src),   64'd0);
    check("flush_ready", 64'(obs_ready), 64'd0);
    for (int c = 0; c < 4; c++) begin
      idle(1'b1);
      check("flush_drop", 64'(obs_valid), 64'd0);
    end

    // Reset mid-stream with three buffers full.
    cycle(4'b0111, {32'd0, 32'd7, 32'd6, 32'd5}, {3'd0, 3'd2, 3'd1, 3'd0}, 1'b0, 1'b0, 1'b1);
    do_reset();
    idle(1'b1);
    check("rst_mid_valid", 64'(obs_valid), 64'd0);
    cycle(4'b1000, {32'h5A5A, 96'd0}, {3'd6, 9'd0}, 1'b0, 1'b0, 1'b1);
    idle(1'b1);
    check("rst_post_src", 64'(obs_src), 64'd3);
    check("rst_post_tag", 64'(obs_tag), 64'd6);

    // Random traffic with occasional flush and reset.
    for (int c = 0; c < 3000; c++) begin
      tg = 3'($urandom);
      cycle(4'($urandom), {$urandom, $urandom, $urandom, $urandom},
            {tg, 9'($urandom)}, ($urandom % 40) == 0, ($urandom % 250) == 0, 1'b1);
    end
    repeat (6) idle(1'b1);
    check("drain_valid", 64'(obs_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
